demux_scan_ctrl: RTL and testbench
==================================

# demux_scan_ctrl

Sequencer for the external 32-channel analog demultiplexer driven from the `uo_out` pins. It accepts byte-wide commands from the host-side IO port. It generates correctly timed address-setup, chip-select and write-strobe sequences on `set_ch`/`cs_n`/`wr_n`, and gates `demux_ena`. It also runs an autonomous round-robin channel scan with a programmable dwell. It sits between the host command decoder (on `uio_in`) and the demux pin drivers in the top-level `tt_um_` wrapper.

## Interface
- `NUM_CH`, 32: demux channel count; must be a power of two.
- `CH_W`, 5: channel address width, $clog2(NUM_CH).
- `SETUP_CYC`, 2: cycles of address/`cs_n` setup before `wr_n` falls; minimum 1.
- `WR_CYC`, 2: cycles `wr_n` is held low; minimum 1.
- `clk  in  1`: system clock; all state on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1`: command present.
- `cmd_op  in  2`: 0 SELECT, 1 SET_DWELL, 2 SET_RANGE, 3 CTRL.
- `cmd_data  in  8`: command payload.
- `cmd_ready  out  1`: command accepted when `cmd_valid & cmd_ready`.
- `set_ch  out  CH_W`: demux address pins.
- `cs_n  out  1`: demux chip select, active low.
- `wr_n  out  1`: demux write/latch strobe, active low; the address latches on the rising edge.
- `demux_ena  out  1`: switch enable, active high.
- `busy  out  1`: high while a latch sequence is in progress.
- `scan_wrap  out  1`: one-cycle pulse when a scan restarts at channel 0.

## Operation
- Registers and their reset values:
  - `dwell`: 8 b, reset 0.
  - `scan_hi`: CH_W b, reset NUM_CH-1.
  - `run`: 0.
  - `en`: 0.
  - `bbm` (break-before-make): 0.
  - `cur_ch`: 0.
- Commands:
  - SELECT: `cur_ch` ← `cmd_data[CH_W-1:0]`. Clears `run`. Starts a latch sequence.
  - SET_DWELL: `dwell` ← `cmd_data`. No latch sequence.
  - SET_RANGE: `scan_hi` ← `cmd_data[CH_W-1:0]`. Upper data bits are ignored.
  - CTRL: `en` ← bit0, `bbm` ← bit2, `run` ← bit1.
    - A `run` transition 0→1 sets `cur_ch` to 0 and starts a latch sequence.
    - Writing `run`=1 while `run` is already 1 has no effect.
- FSM states:
  - IDLE → SETUP on SELECT, or on a `run` 0→1 transition.
  - SETUP lasts SETUP_CYC cycles, then → STROBE.
  - STROBE lasts WR_CYC cycles, then → HOLD.
  - HOLD lasts 1 cycle, then → DWELL if `run`, else → IDLE.
  - DWELL lasts `dwell`+1 cycles, then → SETUP with the next channel.
- Next channel: `cur_ch == scan_hi` ? 0 : `cur_ch`+1.
  - `scan_wrap` pulses in the SETUP entry cycle whenever that channel is 0 and was reached by wrap.
  - The initial `run` start does not pulse `scan_wrap`.
- Per-state outputs:
  - SETUP: `set_ch`=`cur_ch`, `cs_n`=0, `wr_n`=1.
  - STROBE: `cs_n`=0, `wr_n`=0.
  - HOLD: `cs_n`=0, `wr_n`=1.
  - IDLE and DWELL: `cs_n`=1, `wr_n`=1, and `set_ch` keeps the last latched value.
- `demux_ena` = `en`, except that when `bbm`=1 it is forced to 0 from SETUP through HOLD inclusive.
- `cmd_ready` = 1 in IDLE and DWELL, 0 in SETUP/STROBE/HOLD.
- `busy` = 1 in SETUP, STROBE and HOLD.

## Timing
- All outputs are registered. Every output is at its reset value (`set_ch`=0, `cs_n`=1, `wr_n`=1, `demux_ena`=0, `busy`=0, `scan_wrap`=0, `cmd_ready`=0) during reset.
- `cmd_ready` rises in the first clock after reset deasserts.
- Command accepted at edge T:
  - `cs_n` falls and `set_ch` updates at T+1.
  - `wr_n` falls at T+1+SETUP_CYC.
  - `wr_n` rises at T+1+SETUP_CYC+WR_CYC.
  - `cs_n` rises one cycle after `wr_n` rises.
  - Sequence length is SETUP_CYC+WR_CYC+1 cycles (5 at defaults).
- Register-only commands take effect at T+1. `demux_ena` follows `en` at T+1 when not in a bbm window.
- Commands during DWELL:
  - SET_DWELL and SET_RANGE do not restart the current dwell; the new `dwell` applies from the next dwell.
  - A new `scan_hi` below `cur_ch` causes wrap at the next step.
  - CTRL with `run`=0 goes to IDLE at T+1; no further strobes.
  - SELECT aborts the dwell and begins the latch sequence at T+1.
- Asynchronous reset mid-sequence returns all outputs immediately to reset values. It never leaves `wr_n` low.

## Structure
- Package `demux_pkg`:
  - `cmd_op_e` enum (SELECT/SET_DWELL/SET_RANGE/CTRL).
  - `state_e` enum (IDLE/SETUP/STROBE/HOLD/DWELL).
  - CTRL bit-position constants.
  - Default SETUP_CYC/WR_CYC.
- One natural sub-module: `demux_latch_seq`. It is a start-pulse-driven SETUP/STROBE/HOLD timer that drives `cs_n`/`wr_n`/`busy` and returns `done`.
- The parent holds the command registers, DWELL counter and scan stepping.

## Test plan
- Reset → `cs_n`=1, `wr_n`=1, `set_ch`=0, `demux_ena`=0. Assert reset while `wr_n`=0 in STROBE → `wr_n`=1 without waiting for a clock edge.
- SELECT 0x13 at edge T → `set_ch`=19 and `cs_n`=0 at T+1, `wr_n` low T+3..T+4, `cs_n` high at T+6, `cmd_ready`=0 for exactly 5 cycles.
- SET_RANGE 3, SET_DWELL 4, CTRL 0x03 → channels 0,1,2,3,0,… each dwelling 5 cycles; `scan_wrap` pulses once per return to 0; `demux_ena`=1 throughout.
- CTRL 0x07 (bbm) during a scan → `demux_ena`=0 across each 5-cycle latch window, 1 during dwell.
- SELECT 7 issued mid-DWELL of a scan → `run` cleared, a single latch of 7, FSM ends in IDLE, no further strobes.
- `cmd_valid` held high through SETUP/STROBE/HOLD → command not accepted until IDLE, accepted exactly once.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the analog demux scan controller.
package demux_pkg;

  typedef enum logic [1:0] {
    OP_SELECT    = 2'd0,
    OP_SET_DWELL = 2'd1,
    OP_SET_RANGE = 2'd2,
    OP_CTRL      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DWELL  = 3'd4
  } state_e;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_RUN_BIT = 1;
  localparam int CTRL_BBM_BIT = 2;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_WR_CYC    = 2;

  localparam int SEQ_CNT_W = 8;

endpackage

// File: rtl/demux_latch_seq.sv
// Start-pulse driven address latch timer: SETUP -> STROBE -> HOLD on cs_n/wr_n.
// state  | meaning
// IDLE   | no sequence, cs_n/wr_n high, set_ch holds last latched channel
// SETUP  | address and cs_n valid, waiting SETUP_CYC cycles
// STROBE | wr_n low for WR_CYC cycles
// HOLD   | wr_n back high, cs_n still low for one cycle
module demux_latch_seq
  import demux_pkg::*;
#(
  parameter int CH_W      = 5,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int WR_CYC    = DEF_WR_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CH_W-1:0] ch,
  output logic [CH_W-1:0] set_ch,
  output logic            cs_n,
  output logic            wr_n,
  output logic            busy,
  output logic            done
);

  localparam logic [SEQ_CNT_W-1:0] SETUP_LOAD = SEQ_CNT_W'(SETUP_CYC - 1);
  localparam logic [SEQ_CNT_W-1:0] WR_LOAD    = SEQ_CNT_W'(WR_CYC - 1);
  localparam logic [SEQ_CNT_W-1:0] CNT_ONE    = SEQ_CNT_W'(1);

  state_e               phase_q, phase_d;
  logic [SEQ_CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]      set_ch_d;
  logic                 cs_n_d, wr_n_d, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= ST_IDLE;
      cnt_q   <= '0;
      set_ch  <= '0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      busy    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      set_ch  <= set_ch_d;
      cs_n    <= cs_n_d;
      wr_n    <= wr_n_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (phase_q)
      ST_IDLE: begin
        if (start) begin
          phase_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = ST_STROBE;
          cnt_d   = WR_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) phase_d = ST_HOLD;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_HOLD: phase_d = ST_IDLE;
      default: phase_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next phase so pins move on the same edge as the FSM.
  always_comb begin
    set_ch_d = set_ch;
    if (start && (phase_q == ST_IDLE)) set_ch_d = ch;
    cs_n_d = !((phase_d == ST_SETUP) || (phase_d == ST_STROBE) || (phase_d == ST_HOLD));
    wr_n_d = (phase_d != ST_STROBE);
    busy_d = (phase_d != ST_IDLE);
  end

  assign done = (phase_q == ST_HOLD);

endmodule

// File: rtl/demux_scan_ctrl.sv
// Command registers, dwell timer and round-robin scan stepping for the 32-channel demux.
// state | meaning
// IDLE  | waiting for a command, no scan running
// SETUP | latch sequence in flight inside demux_latch_seq (SETUP/STROBE/HOLD)
// DWELL | scan running, holding the current channel for dwell+1 cycles
module demux_scan_ctrl
  import demux_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int WR_CYC    = DEF_WR_CYC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_op,
  input  logic [7:0]      cmd_data,
  output logic            cmd_ready,
  output logic [CH_W-1:0] set_ch,
  output logic            cs_n,
  output logic            wr_n,
  output logic            demux_ena,
  output logic            busy,
  output logic            scan_wrap
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

  state_e          state_q, state_d;
  cmd_op_e         op;
  logic [7:0]      dwell_q, dwell_d;
  logic [7:0]      dwell_cnt_q, dwell_cnt_d;
  logic [CH_W-1:0] scan_hi_q, scan_hi_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic            run_q, run_d;
  logic            en_q, en_d;
  logic            bbm_q, bbm_d;
  logic            accept, start, wrap, seq_done;
  logic            cmd_ready_d, demux_ena_d, scan_wrap_d;

  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      scan_hi_q   <= CH_LAST;
      cur_ch_q    <= '0;
      run_q       <= 1'b0;
      en_q        <= 1'b0;
      bbm_q       <= 1'b0;
      cmd_ready   <= 1'b0;
      demux_ena   <= 1'b0;
      scan_wrap   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      scan_hi_q   <= scan_hi_d;
      cur_ch_q    <= cur_ch_d;
      run_q       <= run_d;
      en_q        <= en_d;
      bbm_q       <= bbm_d;
      cmd_ready   <= cmd_ready_d;
      demux_ena   <= demux_ena_d;
      scan_wrap   <= scan_wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    scan_hi_d   = scan_hi_q;
    cur_ch_d    = cur_ch_q;
    run_d       = run_q;
    en_d        = en_q;
    bbm_d       = bbm_q;
    start       = 1'b0;
    wrap        = 1'b0;

    if (accept) begin
      case (op)
        OP_SELECT: begin
          cur_ch_d = cmd_data[CH_W-1:0];
          run_d    = 1'b0;
          start    = 1'b1;
        end
        OP_SET_DWELL: dwell_d   = cmd_data;
        OP_SET_RANGE: scan_hi_d = cmd_data[CH_W-1:0];
        OP_CTRL: begin
          en_d  = cmd_data[CTRL_EN_BIT];
          bbm_d = cmd_data[CTRL_BBM_BIT];
          run_d = cmd_data[CTRL_RUN_BIT];
          if (cmd_data[CTRL_RUN_BIT] && !run_q) begin
            cur_ch_d = '0;
            start    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_DWELL: begin
        if (start) begin
          state_d = ST_SETUP;
        end else if (!run_d) begin
          state_d = ST_IDLE;
        end else if (dwell_cnt_q == '0) begin
          // >= rather than == so a range shrunk below the current channel wraps at once
          wrap     = (cur_ch_q >= scan_hi_q);
          cur_ch_d = wrap ? '0 : cur_ch_q + CH_ONE;
          start    = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          dwell_cnt_d = dwell_cnt_q - 8'd1;
        end
      end
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        if (seq_done) begin
          if (run_q) begin
            state_d     = ST_DWELL;
            dwell_cnt_d = dwell_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DWELL);
    demux_ena_d = en_d & ~(bbm_d & (state_d == ST_SETUP));
    scan_wrap_d = wrap;
  end

  demux_latch_seq #(
    .CH_W      (CH_W),
    .SETUP_CYC (SETUP_CYC),
    .WR_CYC    (WR_CYC)
  ) u_latch_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ch     (cur_ch_d),
    .set_ch (set_ch),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .busy   (busy),
    .done   (seq_done)
  );

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl against a sequence-position reference model.
module tb_demux_scan_ctrl;

  localparam int NUM_CH    = 32;
  localparam int CH_W      = 5;
  localparam int SETUP_CYC = 2;
  localparam int WR_CYC    = 2;
  localparam int SEQ_LEN   = SETUP_CYC + WR_CYC + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op = 2'd0;
  logic [7:0]      cmd_data = 8'd0;
  logic            cmd_ready;
  logic [CH_W-1:0] set_ch;
  logic            cs_n, wr_n, demux_ena, busy, scan_wrap;

  always #5 clk = ~clk;

  demux_scan_ctrl #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .SETUP_CYC (SETUP_CYC),
    .WR_CYC    (WR_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .set_ch    (set_ch),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .demux_ena (demux_ena),
    .busy      (busy),
    .scan_wrap (scan_wrap)
  );

  int checks = 0;
  int failures = 0;
  bit last_acc = 1'b0;

  // Reference model: m_pos is the cycle index inside a latch sequence (-1 when none),
  // m_dwell_left the remaining dwell cycles minus one (-1 when not dwelling).
  int m_dwell, m_hi, m_cur, m_latched, m_pos, m_dwell_left;
  bit m_run, m_en, m_bbm, m_ready, m_wrap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_dwell = 0; m_hi = NUM_CH - 1; m_cur = 0; m_latched = 0;
    m_pos = -1; m_dwell_left = -1;
    m_run = 0; m_en = 0; m_bbm = 0; m_ready = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input bit v, input int op, input int d);
    bit acc = v && m_ready;
    bit start = 0;
    int hi_old = m_hi;
    m_wrap = 0;
    if (acc) begin
      case (op)
        0: begin m_cur = d % NUM_CH; m_run = 0; start = 1; end
        1: m_dwell = d;
        2: m_hi = d % NUM_CH;
        default: begin
          m_en  = bit'(d & 1);
          m_bbm = bit'((d >> 2) & 1);
          if (((d >> 1) & 1) == 1 && !m_run) begin
            m_run = 1; m_cur = 0; start = 1;
          end else begin
            m_run = bit'((d >> 1) & 1);
          end
        end
      endcase
    end
    if (m_pos >= 0) begin
      if (m_pos == SEQ_LEN - 1) begin
        m_pos = -1;
        if (m_run) m_dwell_left = m_dwell;
      end else begin
        m_pos++;
      end
    end else if (m_dwell_left >= 0 && !start) begin
      if (!m_run) m_dwell_left = -1;
      else if (m_dwell_left == 0) begin
        m_wrap = (m_cur >= hi_old);
        m_cur  = m_wrap ? 0 : m_cur + 1;
        start  = 1;
      end else begin
        m_dwell_left--;
      end
    end
    if (start) begin
      m_pos = 0; m_dwell_left = -1; m_latched = m_cur;
    end
    m_ready = (m_pos < 0);
  endfunction

  task automatic compare_all();
    check_val("cs_n", cs_n, m_pos < 0);
    check_val("wr_n", wr_n, !(m_pos >= SETUP_CYC && m_pos < SETUP_CYC + WR_CYC));
    check_val("busy", busy, m_pos >= 0);
    check_val("set_ch", set_ch, m_latched);
    check_val("cmd_ready", cmd_ready, m_ready);
    check_val("demux_ena", demux_ena, m_en && !(m_bbm && m_pos >= 0));
    check_val("scan_wrap", scan_wrap, m_wrap);
  endtask

  task automatic tick(input bit v, input int op, input int d);
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_data  = 8'(d);
    last_acc  = v && cmd_ready;
    @(posedge clk);
    model_step(v, op, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_cmd(input int op, input int d);
    for (int i = 0; i < 50; i++) begin
      tick(1, op, d);
      if (last_acc) break;
    end
    check_val("send_cmd_accepted", last_acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_dwell();
    bit seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (cs_n === 1'b1 && cmd_ready === 1'b1) begin
        seen = 1;
        break;
      end
      tick(0, 0, 0);
    end
    check_val("wait_dwell", seen, 1);
  endtask

  initial begin
    int rl, wl, wraps, viol, accs, acc_at;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    check_val("rst_cs_n", cs_n, 1);
    check_val("rst_wr_n", wr_n, 1);
    check_val("rst_set_ch", set_ch, 0);
    check_val("rst_demux_ena", demux_ena, 0);
    rst_n = 1'b1;

    tick(0, 0, 0);
    check_val("ready_after_rst", cmd_ready, 1);

    // SELECT 0x13 timing
    tick(1, 0, 8'h13);
    check_val("sel_set_ch", set_ch, 19);
    check_val("sel_cs_n", cs_n, 0);
    rl = int'(!cmd_ready);
    wl = int'(!wr_n);
    for (int k = 2; k <= 7; k++) begin
      tick(0, 0, 0);
      rl += int'(!cmd_ready);
      wl += int'(!wr_n);
      if (k == 3) check_val("sel_wr_fall", wr_n, 0);
      if (k == 6) check_val("sel_cs_rise", cs_n, 1);
    end
    check_val("sel_ready_low_cycles", rl, 5);
    check_val("sel_wr_low_cycles", wl, 2);

    // Scan 0..3 with dwell 4
    send_cmd(2, 3);
    send_cmd(1, 4);
    send_cmd(3, 8'h03);
    wraps = 0;
    viol  = 0;
    for (int k = 2; k <= 85; k++) begin
      tick(0, 0, 0);
      wraps += int'(scan_wrap);
      viol  += int'(demux_ena !== 1'b1);
    end
    check_val("scan_wrap_count", wraps, 2);
    check_val("scan_ena_low", viol, 0);

    // Break-before-make during scan
    send_cmd(3, 8'h07);
    viol = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 0);
      viol += int'(demux_ena !== !busy);
    end
    check_val("bbm_window", viol, 0);

    // SELECT 7 mid-dwell stops the scan
    wait_dwell();
    tick(0, 0, 0);
    send_cmd(0, 7);
    wl = 0;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0, 0);
      wl += int'(!wr_n);
    end
    check_val("abort_wr_low_cycles", wl, 2);
    check_val("abort_set_ch", set_ch, 7);
    check_val("abort_idle_busy", busy, 0);

    // cmd_valid held through a latch sequence
    tick(1, 0, 9);
    accs = 0;
    acc_at = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1, 0, 11);
      if (last_acc) begin
        accs++;
        acc_at = k;
      end
    end
    cmd_valid = 1'b0;
    check_val("held_accept_count", accs, 1);
    check_val("held_accept_cycle", acc_at, 6);
    repeat (6) tick(0, 0, 0);
    check_val("held_set_ch", set_ch, 11);

    // Asynchronous reset while wr_n is low
    tick(1, 0, 5);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check_val("pre_rst_wr_n", wr_n, 0);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_wr_n", wr_n, 1);
    check_val("async_rst_cs_n", cs_n, 1);
    check_val("async_rst_set_ch", set_ch, 0);
    check_val("async_rst_ready", cmd_ready, 0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Random commands against the model
    for (int k = 0; k < 400; k++) begin
      bit v;
      int op, d;
      v  = ($urandom % 4) == 0;
      op = int'($urandom % 4);
      d  = int'($urandom % 256);
      if (op == 1) d = d % 7;
      tick(v, op, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
